// File: rtl/add_defs.sv
// Shared definitions for the pipelined adder/subtractor: operation encodings
// and the bit positions of the condition flags.
package add_defs;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;
    localparam int FLAG_W = 4;

    typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/add_sub_stage.sv
// One slice of the pipelined carry chain. Adds chunk LO_W/CW of the operands,
// writes the partial sum in place of the consumed a-chunk, and forwards the
// not-yet-consumed upper b-chunks. Bits of ar below LO_W already hold result
// chunks from earlier stages; bits above it still hold operand a.
module add_sub_stage #(
    parameter int WIDTH  = 32,
    parameter int CW     = 8,
    parameter int LO_W   = 0,
    parameter int SKEW_W = 24,
    parameter int BO_W   = (SKEW_W > 0) ? SKEW_W : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up_valid,
    output logic                 up_ready,
    output logic                 dn_valid,
    input  logic                 dn_ready,
    input  logic [WIDTH-1:0]     ar_in,
    input  logic [CW+SKEW_W-1:0] b_in,
    input  logic                 c_in,
    input  logic                 ov_in,
    output logic [WIDTH-1:0]     ar_out,
    output logic [BO_W-1:0]      b_out,
    output logic                 c_out,
    output logic                 ov_out
);

    // The stage holding the top chunk is the only one that can see the MSB
    // carries, so it alone produces the overflow bit.
    localparam bit LAST = (LO_W + CW == WIDTH);

    logic             valid_reg;
    logic [WIDTH-1:0] ar_reg;
    logic [WIDTH-1:0] ar_next;
    logic             c_reg;
    logic             c_next;
    logic             ov_reg;
    logic             ov_next;
    logic [CW-1:0]    s_next;
    logic [CW-1:0]    a_ch;
    logic [CW-1:0]    b_ch;
    logic             advance;

    assign a_ch     = ar_in[LO_W +: CW];
    assign b_ch     = b_in[CW-1:0];
    assign advance  = !valid_reg || dn_ready;
    assign up_ready = advance;
    assign dn_valid = valid_reg;
    assign ar_out   = ar_reg;
    assign c_out    = c_reg;
    assign ov_out   = ov_reg;

    // Chunk adder; overflow = carry into MSB xor carry out of MSB.
    always_comb begin
        {c_next, s_next}     = {1'b0, a_ch} + {1'b0, b_ch} + {{CW{1'b0}}, c_in};
        ar_next              = ar_in;
        ar_next[LO_W +: CW]  = s_next;
        ov_next              = LAST ? (c_next ^ s_next[CW-1] ^ a_ch[CW-1] ^ b_ch[CW-1]) : ov_in;
    end

    // Occupancy: refill (or empty) whenever this stage is free to move.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
        end else if (advance) begin
            valid_reg <= up_valid;
        end
    end

    // Payload is captured only on a real transfer so a stalled result stays put.
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_reg <= '0;
            c_reg  <= 1'b0;
            ov_reg <= 1'b0;
        end else if (advance && up_valid) begin
            ar_reg <= ar_next;
            c_reg  <= c_next;
            ov_reg <= ov_next;
        end
    end

    if (SKEW_W > 0) begin : g_skew
        logic [SKEW_W-1:0] b_reg;

        // Upper b-chunks travel alongside the partial result.
        always_ff @(posedge clk) begin
            if (rst) begin
                b_reg <= '0;
            end else if (advance && up_valid) begin
                b_reg <= b_in[CW +: SKEW_W];
            end
        end

        assign b_out = b_reg;
    end else begin : g_noskew
        assign b_out = '0;
    end

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready flow control.
// The carry chain is cut into STAGES chunks; the last stage's registers are
// the output register and the flags are decoded from them.
module add_sub_pipe
    import add_defs::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int CW = WIDTH / STAGES;

    logic [WIDTH-1:0] bx;
    logic             c0;
    logic             stg_valid [STAGES];
    logic             stg_ready [STAGES];
    logic             stg_carry [STAGES];
    logic             stg_ovf   [STAGES];
    logic [WIDTH-1:0] stg_ar    [STAGES];
    flags_t           flags;

    // Subtraction is a + ~b + ~borrow.
    always_comb begin
        bx = (sub == SUB) ? ~b : b;
        c0 = (sub == SUB) ? ~cin : cin;
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
        localparam int SKEW_W = (STAGES - 1 - gi) * CW;
        localparam int BO_W   = (SKEW_W > 0) ? SKEW_W : 1;

        logic [WIDTH-1:0]     ar_i;
        logic [CW+SKEW_W-1:0] b_i;
        logic                 c_i;
        logic                 v_i;
        logic                 ov_i;
        logic                 dn_rdy;
        logic [BO_W-1:0]      b_q;

        if (gi == 0) begin : g_first
            assign ar_i = a;
            assign b_i  = bx;
            assign c_i  = c0;
            assign v_i  = in_valid;
            assign ov_i = 1'b0;
        end else begin : g_chain
            assign ar_i = stg_ar[gi-1];
            assign b_i  = gen_stage[gi-1].b_q;
            assign c_i  = stg_carry[gi-1];
            assign v_i  = stg_valid[gi-1];
            assign ov_i = stg_ovf[gi-1];
        end

        if (gi == STAGES - 1) begin : g_last
            logic unused_b_tail;
            assign dn_rdy        = out_ready;
            assign unused_b_tail = b_q[0];
        end else begin : g_mid
            assign dn_rdy = stg_ready[gi+1];
        end

        add_sub_stage #(
            .WIDTH  (WIDTH),
            .CW     (CW),
            .LO_W   (gi * CW),
            .SKEW_W (SKEW_W)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (v_i),
            .up_ready (stg_ready[gi]),
            .dn_valid (stg_valid[gi]),
            .dn_ready (dn_rdy),
            .ar_in    (ar_i),
            .b_in     (b_i),
            .c_in     (c_i),
            .ov_in    (ov_i),
            .ar_out   (stg_ar[gi]),
            .b_out    (b_q),
            .c_out    (stg_carry[gi]),
            .ov_out   (stg_ovf[gi])
        );
    end

    assign in_ready  = stg_ready[0];
    assign out_valid = stg_valid[STAGES-1];
    assign sum       = stg_ar[STAGES-1];

    // Flags from the registered result; zero is qualified so it reads 0 when idle.
    always_comb begin
        flags         = '0;
        flags[FLAG_C] = stg_carry[STAGES-1];
        flags[FLAG_V] = stg_ovf[STAGES-1];
        flags[FLAG_Z] = out_valid && (sum == '0);
        flags[FLAG_N] = sum[WIDTH-1];
    end

    assign cout = flags[FLAG_C];
    assign ovf  = flags[FLAG_V];
    assign zero = flags[FLAG_Z];
    assign neg  = flags[FLAG_N];

endmodule

// File: tb/tb_add_sub_pipe.sv
// Directed and random checks of add_sub_pipe (WIDTH=32, STAGES=4) against a
// queue of expected {flags, sum} words.
module tb_add_sub_pipe;
    import add_defs::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout, ovf, zero, neg;

    logic        rand_bp = 1'b0;
    logic        out_rdy_man = 1'b0;
    logic        out_rdy_rnd = 1'b1;
    assign out_ready = rand_bp ? out_rdy_rnd : out_rdy_man;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [35:0] exp_q [$];
    int          pop_cyc [$];
    logic [35:0] cur_exp = '0;

    always #5 clk = ~clk;

    add_sub_pipe #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        out_rdy_rnd = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] dut_word();
        flags_t fl;
        fl         = '0;
        fl[FLAG_C] = cout;
        fl[FLAG_V] = ovf;
        fl[FLAG_Z] = zero;
        fl[FLAG_N] = neg;
        return {fl, sum};
    endfunction

    // Reference: a +/- b +/- cin computed with wide arithmetic.
    function automatic logic [35:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic ms, input logic mc);
        logic [32:0] r;
        longint      sr;
        int          ia, ib;
        flags_t      fl;
        longint      hi, lo;
        ia = ma;
        ib = mb;
        hi = (longint'(1) <<< 31) - 1;
        lo = -(longint'(1) <<< 31);
        fl = '0;
        if (!ms) begin
            r  = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
            sr = longint'(ia) + longint'(ib) + longint'(mc);
            fl[FLAG_C] = r[32];
        end else begin
            r  = {1'b0, ma} - {1'b0, mb} - {32'd0, mc};
            sr = longint'(ia) - longint'(ib) - longint'(mc);
            fl[FLAG_C] = ~r[32];
        end
        fl[FLAG_V] = (sr > hi) || (sr < lo);
        fl[FLAG_Z] = (r[31:0] == 32'd0);
        fl[FLAG_N] = r[31];
        return {fl, r[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: every valid output cycle must show the oldest outstanding result.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(1), 64'(0));
                end else begin
                    check("result", 64'(dut_word()), 64'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pop_cyc.push_back(cyc);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    // Present one operation and hold it until accepted; returns at posedge+1.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                        input logic tc, input logic [35:0] te);
        a        = ta;
        b        = tb_v;
        sub      = ts;
        cin      = tc;
        cur_exp  = te;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("send_timeout", 64'(1), 64'(0));
    endtask

    task automatic send_rand();
        logic [31:0] ta, tv;
        logic        ts, tc;
        ta = pick();
        tv = pick();
        ts = 1'($urandom_range(0, 1));
        tc = 1'($urandom_range(0, 1));
        send(ta, tv, ts, tc, model(ta, tv, ts, tc));
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int lat, acc, stale, t0, occ;

        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 64'({out_valid, dut_word()}), 64'(0));
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Test 1: all-ones add, with latency measurement
        out_rdy_man = 1'b1;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, ADD, 1'b0, {4'h9, 32'hFFFF_FFFE});
        idle();
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(4));
        repeat (4) @(posedge clk);
        #1;

        // Tests 2-3 plus a few more hand-computed corners
        send(32'h7FFF_FFFF, 32'h0000_0001, ADD, 1'b0, {4'hA, 32'h8000_0000});
        send(32'h0000_0000, 32'h0000_0001, SUB, 1'b0, {4'h8, 32'hFFFF_FFFF});
        send(32'h0000_0005, 32'h0000_0005, SUB, 1'b0, {4'h5, 32'h0000_0000});
        send(32'h0000_0005, 32'h0000_0005, SUB, 1'b1, {4'h8, 32'hFFFF_FFFF});
        send(32'h8000_0000, 32'h0000_0001, SUB, 1'b0, {4'h3, 32'h7FFF_FFFF});
        send(32'h0000_0000, 32'h0000_0000, ADD, 1'b1, {4'h0, 32'h0000_0001});
        send(32'h0000_0000, 32'h0000_0000, ADD, 1'b0, {4'h4, 32'h0000_0000});
        send(32'h0000_00FF, 32'h0000_0001, ADD, 1'b0, {4'h0, 32'h0000_0100});
        idle();
        wait_drain(20);
        check("drain_directed", 64'(exp_q.size()), 64'(0));

        // Test 4a: 16 back-to-back ops, results on consecutive cycles
        t0 = cyc;
        for (int i = 0; i < 16; i++) send_rand();
        idle();
        check("b2b_accept_cycles", 64'(cyc - t0), 64'(16));
        wait_drain(40);
        check("b2b_drain", 64'(exp_q.size()), 64'(0));
        check("b2b_consecutive", 64'(pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-16]), 64'(15));

        // Test 4b: 6 cycles of backpressure, only 4 ops fit
        out_rdy_man = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            a        = pick();
            b        = pick();
            sub      = 1'($urandom_range(0, 1));
            cin      = 1'($urandom_range(0, 1));
            cur_exp  = model(a, b, sub, cin);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        check("bp_accepts", 64'(acc), 64'(4));
        check("bp_in_ready", 64'(in_ready), 64'(0));

        // Full pipe with both sides transferring: occupancy stays at 4
        out_rdy_man = 1'b1;
        for (int i = 0; i < 3; i++) send_rand();
        occ = exp_q.size();
        check("full_occupancy", 64'(occ), 64'(4));
        idle();
        wait_drain(20);
        check("drain_bp", 64'(exp_q.size()), 64'(0));

        // Test 5: reset with 3 ops in flight
        for (int i = 0; i < 3; i++) send_rand();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_flush", 64'({out_valid, dut_word()}), 64'(0));
        rst = 1'b0;
        check("rst_flush_ready", 64'(in_ready), 64'(1));
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale", 64'(stale), 64'(0));
        @(posedge clk);
        #1;

        // Test 6: random traffic with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                send_rand();
            end else begin
                idle();
                @(posedge clk);
                #1;
            end
        end
        idle();
        rand_bp = 1'b0;
        wait_drain(50);
        check("final_drain", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
